// File: rtl/counter_sequencer.sv
// Shared up/down counter driven by host commands and a programmable tick divider.
// Host commands win arbitration; one displaced tick is held in pend, a second is lost (overrun).
module counter_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 24
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic             free_run,
  input  logic [DIV_W-1:0] div_reload,
  output logic [WIDTH-1:0] count,
  output logic             evt_zero,
  output logic             evt_max,
  output logic             evt_done,
  output logic             overrun,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StFree = 2'b01,
    StRun  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OpClear    = 2'b00,
    OpStepUp   = 2'b01,
    OpStepDown = 2'b10,
    OpRun      = 2'b11
  } op_e;

  logic [DIV_W-1:0] div_q;
  logic             tick_q;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] runleft_q, runleft_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             overrun_q, overrun_d;
  logic             evt_zero_q, evt_max_q, evt_done_q;
  logic             evt_done_d;

  logic   cmd_acc;
  logic   counting;
  logic   fresh;
  logic   pend_live;
  logic   apply_tick;
  logic   upd;
  state_e rest_state;

  assign cmd_ready = 1'b1;
  assign cmd_acc   = cmd_valid & cmd_ready;
  assign counting  = (state_q != StIdle);
  assign fresh     = tick_q & counting;
  // A pending tick is only meaningful while counting; IDLE drops it.
  assign pend_live = pend_q & counting;
  assign rest_state = free_run ? StFree : StIdle;

  always_comb begin
    count_d    = count_q;
    runleft_d  = runleft_q;
    pend_d     = 1'b0;
    overrun_d  = overrun_q;
    evt_done_d = 1'b0;
    upd        = 1'b0;
    apply_tick = 1'b0;
    state_d    = (state_q == StRun) ? StRun : rest_state;

    if (cmd_acc) begin
      unique case (cmd_op)
        OpClear: begin
          count_d   = '0;
          overrun_d = 1'b0;
          upd       = 1'b1;
        end
        OpStepUp: begin
          count_d = count_q + WIDTH'(1);
          upd     = 1'b1;
        end
        OpStepDown: begin
          count_d = count_q - WIDTH'(1);
          upd     = 1'b1;
        end
        OpRun: begin
          if (cmd_arg != '0) begin
            runleft_d = cmd_arg;
            state_d   = StRun;
          end else begin
            runleft_d = '0;
            state_d   = rest_state;
          end
        end
        default: ;
      endcase

      // A new RUN discards any pended tick; other commands displace ticks into pend.
      if (cmd_op != OpRun) begin
        pend_d = fresh | pend_live;
        if (fresh && pend_live && (cmd_op != OpClear)) begin
          overrun_d = 1'b1;
        end
      end
    end else if (pend_live) begin
      apply_tick = 1'b1;
      pend_d     = fresh;
    end else if (fresh) begin
      apply_tick = 1'b1;
    end

    if (apply_tick) begin
      count_d = count_q + WIDTH'(1);
      upd     = 1'b1;
      if (state_q == StRun) begin
        runleft_d = runleft_q - WIDTH'(1);
        if (runleft_q == WIDTH'(1)) begin
          evt_done_d = 1'b1;
          state_d    = rest_state;
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      div_q      <= div_reload;
      tick_q     <= 1'b0;
      state_q    <= StIdle;
      runleft_q  <= '0;
      pend_q     <= 1'b0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      evt_zero_q <= 1'b0;
      evt_max_q  <= 1'b0;
      evt_done_q <= 1'b0;
    end else begin
      if (div_q == '0) begin
        div_q  <= div_reload;
        tick_q <= 1'b1;
      end else begin
        div_q  <= div_q - DIV_W'(1);
        tick_q <= 1'b0;
      end
      state_q    <= state_d;
      runleft_q  <= runleft_d;
      pend_q     <= pend_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      evt_zero_q <= upd && (count_d == '0) && (count_q != '0);
      evt_max_q  <= upd && (count_d == '1) && (count_q != '1);
      evt_done_q <= evt_done_d;
    end
  end

  assign count    = count_q;
  assign evt_zero = evt_zero_q;
  assign evt_max  = evt_max_q;
  assign evt_done = evt_done_q;
  assign overrun  = overrun_q;
  assign state    = state_q;

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

- Sequences a single shared up/down counter (default 8-bit) driven from two sources:
  - host commands arriving from the okHost endpoint side, already in the `sys_clk` domain (e.g. from a trigger-in);
  - an internal programmable tick divider.
- Arbitrates host commands against divider ticks, runs bounded "count N ticks" jobs and free-run mode.
- Emits single-cycle event pulses suitable for trigger-out endpoints.
- Sits between the endpoint wiring and the LED/wire-out consumers of the count.

## Interface
Parameters:
- `WIDTH`, 8: counter width.
- `DIV_W`, 24: divider width.

Ports:
- `sys_clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `cmd_valid`  in  1  host command strobe.
- `cmd_ready`  out  1  always 1 after reset (the block never stalls the host); a command is accepted when `cmd_valid & cmd_ready`.
- `cmd_op`  in  2  command code:
  - 00 CLEAR
  - 01 STEP_UP
  - 10 STEP_DOWN
  - 11 RUN
- `cmd_arg`  in  WIDTH  RUN tick count; 0 means abort the current RUN.
- `free_run`  in  1  level; enables continuous tick counting whenever no RUN is active.
- `div_reload`  in  DIV_W  tick period minus 1; sampled at each divider reload.
- `count`  out  WIDTH  current counter value.
- `evt_zero`  out  1  one-cycle pulse when `count` becomes 0 from a nonzero value.
- `evt_max`  out  1  one-cycle pulse when `count` becomes all-ones from another value.
- `evt_done`  out  1  one-cycle pulse when a RUN completes normally.
- `overrun`  out  1  sticky; set when a tick is lost.
- `state`  out  2  current state: 00 IDLE, 01 FREE, 10 RUN.

## Operation
Divider:
- `div` decrements every cycle.
- When `div == 0`: reload from `div_reload` and register `tick = 1` for the next cycle.
- Tick period is `div_reload + 1` cycles.

States:
- IDLE: ticks are discarded and never pended.
- FREE: each applied tick increments `count`.
- RUN: each applied tick increments `count` and decrements `runleft`.

State transitions (evaluated every cycle):
- Accepted RUN with `cmd_arg != 0`, from any state: `runleft <= cmd_arg`; state becomes RUN; `pend` is cleared.
- Accepted RUN with `cmd_arg == 0`: state becomes FREE if `free_run`, else IDLE; `pend` is cleared; no `evt_done`.
- RUN, tick applied while `runleft == 1`: `evt_done` pulses; state becomes FREE or IDLE per `free_run`.
- Outside RUN: state follows `free_run` (IDLE↔FREE) in the next cycle.

Arbitration priority: accepted host command > pending tick > fresh tick. At most one of these updates `count` per cycle.
- Command accepted while a countable tick (fresh or pending) exists:
  - the command executes;
  - one tick is held in `pend`.
- Fresh tick arrives while `pend = 1` and a command is also accepted:
  - the fresh tick is dropped;
  - `overrun <= 1`.
- No command accepted and `pend = 1`:
  - the pending tick is applied;
  - a simultaneous fresh tick re-fills `pend`.

Commands:
- CLEAR: `count <= 0`; `overrun <= 0`; state and `runleft` unchanged.
- STEP_UP / STEP_DOWN: `count` ±1 modulo 2^WIDTH; `runleft` unaffected.

Arithmetic and events:
- All arithmetic wraps modulo 2^WIDTH: 0xFF+1 = 0x00; 0x00-1 = 0xFF.
- Events are registered with the `count` update: `evt_zero <= upd & next == 0 & count != 0` (`evt_max` analogous).
- CLEAR on a counter that is already 0 produces no pulse.

Reset:
- `count = 0`, `state = IDLE`, `runleft = 0`, `pend = 0`, `tick = 0`.
- `overrun = 0`, all `evt_* = 0`, `cmd_ready = 1`, `div <= div_reload`.
- Reset mid-RUN aborts the RUN with no `evt_done`.

## Timing
- Command accepted at edge N: `count` and events are visible after edge N (1-cycle latency).
- `div` reaches 0 in cycle k: `tick` is high in cycle k+1; `count` updates at the end of cycle k+1.
- A deferred tick lands exactly one cycle after the blocking command, provided no further command is accepted.
- `evt_done` coincides with the final `count` update; `state` changes at the same edge.
- `div_reload` changes take effect at the next reload only.

## Test plan
- Reset: assert `reset` 2 cycles with random inputs → `count = 0`, `state = IDLE`, all `evt_*` = 0, `overrun = 0`, `cmd_ready = 1`.
- Free-run: `free_run = 1`, `div_reload = 3`, 40 cycles → `count = 10`, increments exactly 4 cycles apart, `state = FREE`.
- RUN: `free_run = 0`, `div_reload = 3`, RUN `cmd_arg = 5` → `count` rises by exactly 5, one `evt_done` on the 5th tick, `state = IDLE`, later ticks ignored; RUN `cmd_arg = 0` mid-run → stops, no `evt_done`.
- Wrap: `count = 0xFE`, STEP_UP ×2 → 0xFF with `evt_max`, then 0x00 with `evt_zero`; STEP_DOWN → 0xFF with `evt_max`; CLEAR at 0 → no pulse.
- Collision: FREE, `div_reload = 0`, STEP_UP held on 3 consecutive cycles → `count +3` from commands, `pend` applied the following cycle, `overrun = 1`; then CLEAR → `count = 0`, `overrun = 0`.
- Reset mid-RUN: RUN `cmd_arg = 200`, `reset` after 7 ticks → `count = 0`, `state = IDLE`, no `evt_done`, and no increments afterward with `free_run = 0`.
